accelbrot_loop_exit_v2: RTL and testbench

Parametrised successor to the loop-exit stage of the Mandelbrot iteration ring. It receives NWORDS-word multi-precision bursts and decides, per burst, whether the pixel leaves the loop or recirculates. A burst leaves on escape, on reaching a programmable iteration limit, or on flush. Exiting pixels push {tag, count} into an internal FIFO; all others are re-emitted NWORDS cycles later. Generalises variable count (NVARS), FIFO depth and almost-full margin, and adds the iteration limit, flush mode and stall statistics.

---
 rtl/accelbrot_loop_exit_v2.sv | 169 ++++++++++++++++
 tb/tb_accelbrot_loop_exit_v2.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/accelbrot_loop_exit_v2.sv
// Loop-exit stage of the Mandelbrot iteration ring: per-burst exit/recirculate decision,
// NWORDS-cycle payload delay and a first-word-fall-through exit FIFO of {tag, count}.
module accelbrot_loop_exit_v2 #(
    parameter int unsigned NWORDS       = 8,
    parameter int unsigned WWIDTH       = 34,
    parameter int unsigned NVARS        = 4,
    parameter int unsigned CWIDTH       = 16,
    parameter int unsigned TWIDTH       = 24,
    parameter int unsigned FIFO_DEPTH   = 145,
    parameter int unsigned AFULL_MARGIN = 8
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [CWIDTH-1:0]         cfg_max_iter,
    input  logic                      cfg_flush,
    output logic [31:0]               sts_num_exited,
    output logic [31:0]               sts_num_stalled,
    input  logic [NVARS*WWIDTH-1:0]   in_data,
    input  logic [TWIDTH-1:0]         in_tag,
    input  logic [CWIDTH-1:0]         in_count,
    input  logic                      in_finish,
    input  logic                      in_start,
    input  logic                      in_valid,
    output logic [NVARS*WWIDTH-1:0]   out_data,
    output logic [TWIDTH-1:0]         out_tag,
    output logic [CWIDTH-1:0]         out_count,
    output logic                      out_finish,
    output logic                      out_start,
    output logic                      out_valid,
    output logic [TWIDTH-1:0]         exit_tag,
    output logic [CWIDTH-1:0]         exit_count,
    output logic                      exit_valid,
    input  logic                      exit_ready
);

    localparam int unsigned DW   = NVARS * WWIDTH;
    localparam int unsigned EW   = TWIDTH + CWIDTH;
    localparam int unsigned CntW = $clog2(NWORDS);
    localparam int unsigned RemW = $clog2(NWORDS + 1);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic              start_q;
    logic [TWIDTH-1:0] tag_q;
    logic [CWIDTH-1:0] count_q;
    logic              finish_q;
    logic              push_q;
    logic [EW-1:0]     push_data_q;
    logic [31:0]       stalled_q, exited_q;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [DW-1:0]     dly_q [NWORDS];

    logic          decision, eligible, afull, exit_now, stall_now, pop;
    logic [OccW:0] occ_pending;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        cnt_d = '0;
        if (in_valid && in_start) begin
            cnt_d = CntW'(1);
        end else if (cnt_q != '0 && cnt_q != CntW'(NWORDS - 1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A push registered last cycle has not reached occ_q yet, so count it toward afull.
    assign occ_pending = {1'b0, occ_q} + {{OccW{1'b0}}, push_q};
    assign afull       = occ_pending >= (OccW + 1)'(FIFO_DEPTH - AFULL_MARGIN);
    assign decision    = (cnt_q == CntW'(NWORDS - 1));
    assign eligible    = in_finish || cfg_flush ||
                         (cfg_max_iter != '0 && in_count >= cfg_max_iter);
    assign exit_now    = decision && eligible && !afull;
    assign stall_now   = decision && eligible && afull;
    assign pop         = (occ_q != '0) && exit_ready;

    always_comb begin
        rem_d = '0;
        if (decision) begin
            rem_d = exit_now ? '0 : RemW'(NWORDS);
        end else if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (push_q && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_q && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            start_q     <= 1'b0;
            tag_q       <= '0;
            count_q     <= '0;
            finish_q    <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            stalled_q   <= '0;
            exited_q    <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            start_q     <= decision && !exit_now;
            push_q      <= exit_now;
            push_data_q <= {in_tag, in_count};
            if (decision) begin
                tag_q    <= in_tag;
                count_q  <= in_count;
                finish_q <= in_finish;
            end
            if (stall_now && stalled_q != '1) begin
                stalled_q <= stalled_q + 1'b1;
            end
            occ_q    <= occ_d;
            exited_q <= 32'(occ_q);
            if (push_q) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && push_q) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    // Payload delay line carries no control, so it needs no reset.
    always_ff @(posedge clk) begin
        dly_q[0] <= in_data;
        for (int i = 1; i < int'(NWORDS); i++) begin
            dly_q[i] <= dly_q[i-1];
        end
    end

    assert property (@(posedge clk) disable iff (!rstn)
        !(push_q && !pop && occ_q == OccW'(FIFO_DEPTH)));

    assign out_data        = dly_q[NWORDS-1];
    assign out_tag         = tag_q;
    assign out_count       = count_q;
    assign out_finish      = finish_q;
    assign out_start       = start_q;
    assign out_valid       = (rem_q != '0);
    assign exit_valid      = (occ_q != '0);
    assign {exit_tag, exit_count} = mem_q[rd_ptr_q];
    assign sts_num_exited  = exited_q;
    assign sts_num_stalled = stalled_q;

endmodule

// File: tb/tb_accelbrot_loop_exit_v2.sv
// Directed bench for accelbrot_loop_exit_v2 with NWORDS=4 and a 16-entry FIFO (margin 8).
module tb_accelbrot_loop_exit_v2;

    localparam int NW = 4;
    localparam int WW = 34;
    localparam int NV = 4;
    localparam int CW = 16;
    localparam int TW = 24;
    localparam int DW = NV * WW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [CW-1:0] cfg_max_iter;
    logic          cfg_flush;
    logic [31:0]   sts_num_exited, sts_num_stalled;
    logic [DW-1:0] in_data, out_data;
    logic [TW-1:0] in_tag, out_tag, exit_tag;
    logic [CW-1:0] in_count, out_count, exit_count;
    logic          in_finish, in_start, in_valid;
    logic          out_finish, out_start, out_valid;
    logic          exit_valid, exit_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    accelbrot_loop_exit_v2 #(
        .NWORDS      (NW),
        .WWIDTH      (WW),
        .NVARS       (NV),
        .CWIDTH      (CW),
        .TWIDTH      (TW),
        .FIFO_DEPTH  (16),
        .AFULL_MARGIN(8)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .cfg_max_iter   (cfg_max_iter),
        .cfg_flush      (cfg_flush),
        .sts_num_exited (sts_num_exited),
        .sts_num_stalled(sts_num_stalled),
        .in_data        (in_data),
        .in_tag         (in_tag),
        .in_count       (in_count),
        .in_finish      (in_finish),
        .in_start       (in_start),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .out_count      (out_count),
        .out_finish     (out_finish),
        .out_start      (out_start),
        .out_valid      (out_valid),
        .exit_tag       (exit_tag),
        .exit_count     (exit_count),
        .exit_valid     (exit_valid),
        .exit_ready     (exit_ready)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the decision edge (D+1).
    task automatic send(input logic [TW-1:0] tag, input logic [CW-1:0] count,
                        input logic fin, input logic [DW-1:0] base);
        for (int w = 0; w < NW; w++) begin
            in_valid  = 1'b1;
            in_start  = (w == 0);
            in_data   = base + DW'(w);
            in_tag    = tag;
            in_count  = count;
            in_finish = fin;
            step();
        end
        in_valid  = 1'b0;
        in_start  = 1'b0;
        in_data   = '0;
        in_finish = 1'b0;
    endtask

    task automatic run_single(input logic [TW-1:0] tag, input logic [CW-1:0] count,
                              input logic fin, input logic expect_exit);
        send(tag, count, fin, DW'(32'h5000));
        check("slot_valid_d1", out_valid, !expect_exit);
        check("slot_finish", out_finish, fin);
        check("slot_count", out_count, count);
        step();
        check("exit_valid_d2", exit_valid, expect_exit);
        check("slot_valid_d2", out_valid, !expect_exit);
        if (expect_exit) begin
            check("exit_tag", exit_tag, tag);
            check("exit_count", exit_count, count);
        end
        repeat (5) step();
    endtask

    task automatic check_recirc(input logic [TW-1:0] tag, input logic [CW-1:0] count,
                                input logic [DW-1:0] base);
        send(tag, count, 1'b0, base);
        check("rc_start", out_start, 1'b1);
        check("rc_valid", out_valid, 1'b1);
        check("rc_tag", out_tag, tag);
        check("rc_count", out_count, count);
        check("rc_data0", out_data, base);
        for (int k = 1; k < NW; k++) begin
            step();
            check("rc_start_low", out_start, 1'b0);
            check("rc_valid_k", out_valid, 1'b1);
            check("rc_data_k", out_data, base + DW'(k));
        end
        step();
        check("rc_valid_end", out_valid, 1'b0);
        check("rc_no_exit", exit_valid, 1'b0);
        repeat (2) step();
    endtask

    initial begin
        rstn         = 1'b0;
        cfg_max_iter = '0;
        cfg_flush    = 1'b0;
        in_data      = '0;
        in_tag       = '0;
        in_count     = '0;
        in_finish    = 1'b0;
        in_start     = 1'b0;
        in_valid     = 1'b0;
        exit_ready   = 1'b1;
        repeat (3) step();

        check("rst_out_start", out_start, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_tag", out_tag, '0);
        check("rst_out_count", out_count, '0);
        check("rst_out_finish", out_finish, 1'b0);
        check("rst_exit_valid", exit_valid, 1'b0);
        check("rst_sts_exited", sts_num_exited, '0);
        check("rst_sts_stalled", sts_num_stalled, '0);
        rstn = 1'b1;
        step();

        // Plain recirculation.
        check_recirc(24'h000011, 16'd5, DW'(36'h1_0000_0100));

        // Escape with the consumer ready.
        send(24'h00ABCD, 16'h0123, 1'b1, DW'(32'h700));
        check("esc_valid_d1", out_valid, 1'b0);
        check("esc_exit_d1", exit_valid, 1'b0);
        step();
        check("esc_exit_valid", exit_valid, 1'b1);
        check("esc_exit_tag", exit_tag, 24'h00ABCD);
        check("esc_exit_count", exit_count, 16'h0123);
        check("esc_valid_d2", out_valid, 1'b0);
        step();
        check("esc_popped", exit_valid, 1'b0);
        check("esc_sts_one", sts_num_exited, 32'd1);
        step();
        check("esc_sts_zero", sts_num_exited, 32'd0);
        repeat (3) step();

        // Iteration limit, then limit disabled.
        cfg_max_iter = 16'd100;
        run_single(24'h000021, 16'd99, 1'b0, 1'b0);
        run_single(24'h000022, 16'd100, 1'b0, 1'b1);
        run_single(24'h000023, 16'hFFFF, 1'b0, 1'b1);
        cfg_max_iter = 16'd0;
        run_single(24'h000024, 16'd99, 1'b0, 1'b0);
        run_single(24'h000025, 16'd100, 1'b0, 1'b0);
        run_single(24'h000026, 16'hFFFF, 1'b0, 1'b0);

        // Backpressure: occupancy 8 reaches afull, bursts 8 and 9 stall.
        exit_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(24'h000200 + TW'(i), CW'(i), 1'b1, DW'(32'h900));
            check("bp_out_valid", out_valid, (i >= 8));
            if (i >= 8) begin
                check("bp_out_finish", out_finish, 1'b1);
            end
        end
        repeat (2) step();
        check("bp_stalled", sts_num_stalled, 32'd2);
        check("bp_exited", sts_num_exited, 32'd8);
        exit_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_drain_valid", exit_valid, 1'b1);
            check("bp_drain_tag", exit_tag, 24'h000200 + TW'(i));
            step();
        end
        check("bp_empty", exit_valid, 1'b0);
        repeat (2) step();
        check("bp_sts_zero", sts_num_exited, 32'd0);
        repeat (4) step();

        // Flush forces non-escaping bursts out.
        cfg_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_single(24'h000300 + TW'(i), CW'(i + 1), 1'b0, 1'b1);
        end
        cfg_flush = 1'b0;

        // Reset at word 2 of an escaping burst; word 3 arrives without a start.
        in_valid = 1'b1; in_start = 1'b1; in_finish = 1'b1;
        in_tag = 24'h000444; in_count = 16'd7;
        step();
        in_start = 1'b0;
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        in_valid = 1'b0; in_finish = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("mr_no_exit", exit_valid, 1'b0);
            check("mr_no_valid", out_valid, 1'b0);
            step();
        end
        check_recirc(24'h000055, 16'd9, DW'(36'h2_0000_0200));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
